// File: rtl/load_store_unit.sv
// load_store_unit
//   Byte-addressed load/store front end for an asynchronous word memory.
//   Handles byte/half/word accesses, sign or zero extension of loads, and
//   read-modify-write for sub-word stores (the memory only writes whole words).
//   Misaligned, out-of-range and illegal-size requests are answered with
//   resp_err and never reach the memory.
//
//   Optional build macro: LSU_ACCESS_COUNT_EN adds load/store/error counters.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req_valid / req_ready    request handshake (ready only while idle)
//   req_we, req_size,        store flag, size (00 byte, 01 half, 10 word),
//   req_signed               load sign-extension
//   req_addr, req_wdata      byte address, right-aligned store data
//   resp_valid               one-cycle completion pulse
//   resp_err, resp_rdata     error flag, extended load data (0 for stores/errors)
//   mem_r_en, mem_w_en       memory strobes (never both high)
//   mem_addr, mem_wdata      word index and write word
//   mem_rdata                combinational read data from memory
//   load_cnt, store_cnt,     (LSU_ACCESS_COUNT_EN only) completed loads,
//   err_cnt                  completed stores, error responses
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | ready for a request
// RD    | memory read: load extraction or RMW merge
// WR    | memory write of full or merged word
// RESP  | response pulse, back to IDLE next cycle
module load_store_unit #(
    parameter int MEM_WORDS_LOG2 = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic        mem_r_en,
    output logic        mem_w_en,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
`ifdef LSU_ACCESS_COUNT_EN
    ,
    output logic [31:0] load_cnt,
    output logic [31:0] store_cnt,
    output logic [31:0] err_cnt
`endif
);

    localparam int AW = MEM_WORDS_LOG2 + 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_RESP
    } state_t;

    state_t      state_q, state_d;
    logic        we_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic [AW-1:0] addr_q;
    logic [31:0] wdata_q;
    logic        err_q;
    logic [31:0] merge_q;
    logic [31:0] rdata_q;

    logic        accept;
    logic        req_err;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_val;
    logic [31:0] merged;
    logic        wr_active;

    assign req_ready = (state_q == S_IDLE);
    assign accept    = req_valid & req_ready;

    assign req_err = (req_size == 2'b11)
                   || ((req_size == 2'b01) && req_addr[0])
                   || ((req_size == 2'b10) && (req_addr[1:0] != 2'b00))
                   || (req_addr[31:AW] != '0);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (req_err)
                        state_d = S_RESP;
                    else if (!req_we)
                        state_d = S_RD;
                    else if (req_size == 2'b10)
                        state_d = S_WR;
                    else
                        state_d = S_RD;
                end
            end
            S_RD:    state_d = we_q ? S_WR : S_RESP;
            S_WR:    state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Lane selection, little-endian: byte lane = addr[1:0], half lane = addr[1].
    always_comb begin
        lane_b = mem_rdata[7:0];
        case (addr_q[1:0])
            2'd0: lane_b = mem_rdata[7:0];
            2'd1: lane_b = mem_rdata[15:8];
            2'd2: lane_b = mem_rdata[23:16];
            2'd3: lane_b = mem_rdata[31:24];
            default: lane_b = mem_rdata[7:0];
        endcase
        lane_h = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

        load_val = mem_rdata;
        case (size_q)
            2'b00:   load_val = {{24{signed_q & lane_b[7]}}, lane_b};
            2'b01:   load_val = {{16{signed_q & lane_h[15]}}, lane_h};
            default: load_val = mem_rdata;
        endcase

        merged = mem_rdata;
        if (size_q == 2'b00) begin
            case (addr_q[1:0])
                2'd0: merged[7:0]   = wdata_q[7:0];
                2'd1: merged[15:8]  = wdata_q[7:0];
                2'd2: merged[23:16] = wdata_q[7:0];
                2'd3: merged[31:24] = wdata_q[7:0];
                default: merged = mem_rdata;
            endcase
        end else if (addr_q[1]) begin
            merged[31:16] = wdata_q[15:0];
        end else begin
            merged[15:0] = wdata_q[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            we_q     <= 1'b0;
            size_q   <= 2'b00;
            signed_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            merge_q  <= '0;
            rdata_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                we_q     <= req_we;
                size_q   <= req_size;
                signed_q <= req_signed;
                addr_q   <= req_addr[AW-1:0];
                wdata_q  <= req_wdata;
                err_q    <= req_err;
                if (req_err)
                    rdata_q <= '0;
            end
            case (state_q)
                S_RD: begin
                    if (we_q)
                        merge_q <= merged;
                    else
                        rdata_q <= load_val;
                end
                // Every store passes through WR right before RESP.
                S_WR:    rdata_q <= '0;
                default: ;
            endcase
        end
    end

    // Gated by rst so a reset landing on the WR cycle never commits a write.
    assign wr_active  = (state_q == S_WR) && !rst;
    assign mem_r_en   = (state_q == S_RD) && !rst;
    assign mem_w_en   = wr_active;
    assign mem_addr   = {{(32-MEM_WORDS_LOG2){1'b0}}, addr_q[AW-1:2]};
    assign mem_wdata  = !wr_active          ? 32'd0 :
                        (size_q == 2'b10)   ? wdata_q : merge_q;
    assign resp_valid = (state_q == S_RESP);
    assign resp_err   = (state_q == S_RESP) && err_q;
    assign resp_rdata = rdata_q;

`ifdef LSU_ACCESS_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            load_cnt  <= '0;
            store_cnt <= '0;
            err_cnt   <= '0;
        end else if (state_q == S_RESP) begin
            if (err_q)
                err_cnt <= err_cnt + 32'd1;
            else if (we_q)
                store_cnt <= store_cnt + 32'd1;
            else
                load_cnt <= load_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: an array models the asynchronous
// memory, a separate reference array tracks expected contents, and each
// request's latency, strobes, response and resulting memory word are checked.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic        mem_r_en;
    logic        mem_w_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
`ifdef LSU_ACCESS_COUNT_EN
    logic [31:0] load_cnt, store_cnt, err_cnt;
`endif

    load_store_unit #(.MEM_WORDS_LOG2(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_err   (resp_err),
        .resp_rdata (resp_rdata),
        .mem_r_en   (mem_r_en),
        .mem_w_en   (mem_w_en),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
`ifdef LSU_ACCESS_COUNT_EN
        ,
        .load_cnt   (load_cnt),
        .store_cnt  (store_cnt),
        .err_cnt    (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    logic [31:0] tb_mem  [1024];
    logic [31:0] ref_mem [1024];

    assign mem_rdata = tb_mem[mem_addr[9:0]];
    always @(posedge clk) if (mem_w_en) tb_mem[mem_addr[9:0]] <= mem_wdata;

    int checks   = 0;
    int failures = 0;
    int exp_loads = 0, exp_stores = 0, exp_errs = 0;
    logic        prev_resp = 1'b0;
    logic [31:0] last_rdata;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wdata);
        logic        err;
        int          idx, sh, exp_lat, exp_rd, exp_wr, lat, n_rd, n_wr, n;
        logic [31:0] w, v, nw, mask;
        logic        ready_bad, addr_bad, overlap, got_err;
        logic [31:0] seen_wdata, got_rdata;

        err = (size == 2'd3) || (size == 2'd1 && addr % 2 != 0)
           || (size == 2'd2 && addr % 4 != 0) || (addr >= 32'd4096);
        idx = int'(addr[11:2]);
        sh  = 8 * int'(addr[1:0]);
        w   = ref_mem[idx];
        nw  = w;
        v   = 32'd0;
        if (err) begin
            exp_lat = 1; exp_rd = 0; exp_wr = 0;
        end else if (!we) begin
            exp_lat = 2; exp_rd = 1; exp_wr = 0;
            if (size == 2'd0) begin
                v = (w >> sh) & 32'hFF;
                if (sgn && v >= 32'd128) v = v - 32'd256;
            end else if (size == 2'd1) begin
                v = (w >> sh) & 32'hFFFF;
                if (sgn && v >= 32'd32768) v = v - 32'd65536;
            end else begin
                v = w;
            end
        end else if (size == 2'd2) begin
            exp_lat = 2; exp_rd = 0; exp_wr = 1;
            nw = wdata;
        end else begin
            exp_lat = 3; exp_rd = 1; exp_wr = 1;
            mask = (size == 2'd0 ? 32'hFF : 32'hFFFF) << sh;
            nw = (w & ~mask) | ((wdata << sh) & mask);
        end

        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
        req_addr = addr; req_wdata = wdata;
        n = 0;
        while (!req_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", {31'd0, req_ready}, 32'd1);
        if (prev_resp) chk("b2b_wait", n, 1);

        n_rd = 0; n_wr = 0; lat = 7;
        ready_bad = 0; addr_bad = 0; overlap = 0; got_err = 0;
        seen_wdata = 32'd0; got_rdata = 32'hX;
        @(posedge clk);
        for (int i = 1; i <= 6; i++) begin
            #1;
            if (mem_r_en) n_rd++;
            if (mem_w_en) begin n_wr++; seen_wdata = mem_wdata; end
            if (mem_r_en && mem_w_en) overlap = 1;
            if ((mem_r_en || mem_w_en) && mem_addr != 32'(idx)) addr_bad = 1;
            if (req_ready) ready_bad = 1;
            if (resp_valid) begin
                lat = i; got_err = resp_err; got_rdata = resp_rdata;
                break;
            end
            @(posedge clk);
        end
        if (lat == 7) chk("resp_timeout", 32'd0, 32'd1);
        prev_resp = (lat != 7);
        chk("latency", lat, exp_lat);
        chk("resp_err", {31'd0, got_err}, {31'd0, err});
        chk("resp_rdata", got_rdata, v);
        chk("rd_cycles", n_rd, exp_rd);
        chk("wr_cycles", n_wr, exp_wr);
        chk("ready_busy", {31'd0, ready_bad}, 32'd0);
        chk("rw_overlap", {31'd0, overlap}, 32'd0);
        chk("mem_addr", {31'd0, addr_bad}, 32'd0);
        if (exp_wr == 1) chk("mem_wdata", seen_wdata, nw);
        last_rdata = got_rdata;
        if (!err) begin
            if (we) ref_mem[idx] = nw;
            chk("mem_word", tb_mem[idx], ref_mem[idx]);
        end
        if (err) exp_errs++;
        else if (we) exp_stores++;
        else exp_loads++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        prev_resp = 1'b0;
        exp_loads = 0; exp_stores = 0; exp_errs = 0;
    endtask

    initial begin
        logic [31:0] a, d, saved;
        logic [1:0]  sz;
        int          n;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
        req_signed = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
        for (int i = 0; i < 1024; i++) begin
            d = $urandom();
            tb_mem[i] = d;
            ref_mem[i] = d;
        end
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_strobes", {30'd0, mem_r_en, mem_w_en}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        rst = 1'b0;

        do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
        chk("dir_word_store", tb_mem[4], 32'hDEADBEEF);
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'd0);
        chk("dir_word_load", last_rdata, 32'hDEADBEEF);

        tb_mem[4] = 32'h11223344; ref_mem[4] = 32'h11223344;
        do_req(1'b1, 2'd0, 1'b0, 32'h11, 32'h000000AA);
        chk("dir_byte_rmw", tb_mem[4], 32'h1122AA44);
        do_req(1'b0, 2'd0, 1'b1, 32'h11, 32'd0);
        chk("dir_lb_signed", last_rdata, 32'hFFFFFFAA);
        do_req(1'b0, 2'd0, 1'b0, 32'h11, 32'd0);
        chk("dir_lb_unsigned", last_rdata, 32'h000000AA);
        do_req(1'b0, 2'd1, 1'b1, 32'h12, 32'd0);
        chk("dir_lh_signed", last_rdata, 32'h00001122);

        do_req(1'b0, 2'd2, 1'b0, 32'h02, 32'd0);
        do_req(1'b1, 2'd1, 1'b0, 32'h03, 32'h1234);
        do_req(1'b0, 2'd3, 1'b0, 32'h20, 32'd0);
        do_req(1'b0, 2'd2, 1'b0, 32'h00001000, 32'd0);

        // Reset landing on the WR cycle of a byte store.
        @(negedge clk);
        saved = tb_mem[8];
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_signed = 1'b0;
        req_addr = 32'h21; req_wdata = 32'h5A;
        n = 0;
        while (!req_ready && n < 10) begin @(negedge clk); n++; end
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("rstwr_in_wr", {31'd0, mem_w_en}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rstwr_w_en_gated", {31'd0, mem_w_en}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        chk("rstwr_mem_kept", tb_mem[8], saved);
        chk("rstwr_ready", {31'd0, req_ready}, 32'd1);
        n = 0;
        repeat (4) begin @(negedge clk); if (resp_valid) n++; end
        chk("rstwr_no_resp", n, 0);
        prev_resp = 1'b0;
        exp_loads = 0; exp_stores = 0; exp_errs = 0;

        for (int k = 0; k < 300; k++) begin
            case ($urandom_range(0, 9))
                0:       a = $urandom();
                1, 2, 3: a = $urandom_range(0, 4095);
                default: a = $urandom_range(0, 63);
            endcase
            sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            if (sz == 2'd1 && $urandom_range(0, 3) != 0) a[0] = 1'b0;
            if (sz == 2'd2 && $urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom());
            if ($urandom_range(0, 7) == 0) begin
                @(negedge clk);
                req_valid = 1'b0;
                repeat ($urandom_range(0, 3)) @(negedge clk);
                prev_resp = 1'b0;
            end
        end

`ifdef LSU_ACCESS_COUNT_EN
        @(negedge clk);
        chk("cnt_load_rand", load_cnt, exp_loads);
        chk("cnt_store_rand", store_cnt, exp_stores);
        chk("cnt_err_rand", err_cnt, exp_errs);
        do_reset();
        chk("cnt_rst", load_cnt | store_cnt | err_cnt, 32'd0);
        do_req(1'b0, 2'd2, 1'b0, 32'h40, 32'd0);
        do_req(1'b1, 2'd0, 1'b0, 32'h41, 32'h77);
        do_req(1'b0, 2'd0, 1'b1, 32'h41, 32'd0);
        do_req(1'b0, 2'd1, 1'b0, 32'h41, 32'd0);
        @(negedge clk);
        chk("cnt_load", load_cnt, 32'd2);
        chk("cnt_store", store_cnt, 32'd1);
        chk("cnt_err", err_cnt, 32'd1);
`else
        do_reset();
        chk("post_rst_ready", {31'd0, req_ready}, 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
